score_scan_ctrl: RTL

- Pong score controller. Holds both players' scores (0-7) and runs the game-over state machine.
- Shares one hexa7seg decoder between the two score digits by time-multiplexing it under a scan prescaler.
- Sits between the ball/collision logic, which supplies the goal pulses, and the board's 7-segment digits and anodes.

---
 rtl/score_scan_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/score_scan_ctrl.sv
// Pong score controller: two 0..7 scores, PLAY/OVER game FSM and a time-multiplexed
// 7-segment scan sharing one hexa7seg decoder. Optional macro BLINK_WINNER_EN blinks the winner.

module hexa7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b0000011;
      4'hc: seg = 7'b1000110;
      4'hd: seg = 7'b0100001;
      4'he: seg = 7'b0000110;
      4'hf: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module score_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       restart,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam logic PLAY = 1'b0;
  localparam logic OVER = 1'b1;

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [2:0] WinVal = 3'(WIN_SCORE);

  logic             state_q, state_d;
  logic [2:0]       p1_q, p1_d, p2_q, p2_d;
  logic [1:0]       winner_q, winner_d;
  logic [ScanW-1:0] presc_q;
  logic             scan_q;
  logic [6:0]       dec_seg;
  logic             blank;

  // Increments only happen in PLAY where scores are below WinVal, so no wrap is possible.
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    if (restart) begin
      state_d  = PLAY;
      p1_d     = 3'd0;
      p2_d     = 3'd0;
      winner_d = 2'b00;
    end else if (state_q == PLAY) begin
      if (goal_p1) begin
        p1_d = p1_q + 3'd1;
        if (p1_d == WinVal) begin
          state_d  = OVER;
          winner_d = 2'b01;
        end
      end else if (goal_p2) begin
        p2_d = p2_q + 3'd1;
        if (p2_d == WinVal) begin
          state_d  = OVER;
          winner_d = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      p1_q     <= 3'd0;
      p2_q     <= 3'd0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
    end
  end

  // Scan prescaler free-runs regardless of game state or restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      scan_q  <= 1'b0;
    end else if (presc_q == ScanLast) begin
      presc_q <= '0;
      scan_q  <= ~scan_q;
    end else begin
      presc_q <= presc_q + ScanW'(1);
    end
  end

`ifdef BLINK_WINNER_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_q;

  always_ff @(posedge clk) begin
    if (reset || restart || (state_q == PLAY && state_d == OVER)) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (state_q == OVER) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BlinkW'(1);
      end
    end
  end

  assign blank = blink_q && ((!scan_q && winner_q == 2'b01) || (scan_q && winner_q == 2'b10));
`else
  assign blank = 1'b0;
`endif

  hexa7seg u_dec (
    .hex (scan_q ? {1'b0, p2_q} : {1'b0, p1_q}),
    .seg (dec_seg)
  );

  assign seg       = blank ? 7'b1111111 : dec_seg;
  assign an        = scan_q ? 2'b01 : 2'b10;
  assign score_p1  = p1_q;
  assign score_p2  = p2_q;
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;
endmodule
